// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed seven-segment scan controller.
// Drives DIGITS digit codes onto a shared segment bus with a one-hot digit
// select, a per-digit on-time (DWELL) and an inter-digit dead-time (BLANK).
// Digit writes land in a shadow copy and reach the displayed (active) copy
// only at frame boundaries, so a frame never shows a half-updated value.
// Optional leading-zero blanking: define SEG7_SCAN_LZB_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | display dark, active copy tracks shadow every cycle
// S_ON    | digit idx lit for DWELL cycles
// S_BLANK | dead-time between digits, all outputs dark for BLANK cycles
module seg7_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 1000,
  parameter int BLANK  = 16,
  localparam int AW    = (DIGITS > 2) ? $clog2(DIGITS) : 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [3:0]        wr_data_i,
  output logic [6:0]        seg_o,
  output logic [DIGITS-1:0] an_o,
  output logic              frame_tick_o
);

  // One shared down-counter serves both the dwell and the blank phase.
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [AW-1:0] LAST_IDX = AW'(DIGITS - 1);
  localparam logic [3:0]    CODE_BLANK = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     tick_q, tick_d;
  logic [DIGITS-1:0][3:0]   shadow_q, shadow_d;
  logic [DIGITS-1:0][3:0]   active_q, active_d;
  logic [6:0]               seg_q, seg_d;
  logic [DIGITS-1:0]        an_q, an_d;
  logic [DIGITS-1:0]        lzb_mask;
  logic                     addr_ok;
  logic [AW-1:0]            idx_next;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      4'd10:   s = 7'b1100111;
      4'd11:   s = 7'b0110111;
      4'd12:   s = 7'b0000001;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // The frame copy cycle is exactly the cycle frame_tick is high; holding
  // off writes then keeps shadow stable while it is copied.
  assign wr_ready_o   = ~tick_q;
  assign seg_o        = seg_q;
  assign an_o         = an_q;
  assign frame_tick_o = tick_q;

  assign addr_ok  = ({1'b0, wr_addr_i} < (AW + 1)'(DIGITS));
  assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  // Shadow write port; accepted writes to a nonexistent digit are dropped.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_valid_i && wr_ready_o && addr_ok) begin
      shadow_d[wr_addr_i] = wr_data_i;
    end
  end

  // Active copy follows shadow while idle, otherwise only on the copy cycle.
  // Using shadow_d lets a write made in the same cycle as enable show in the
  // very first lit cycle.
  always_comb begin
    active_d = active_q;
    if ((state_q == S_IDLE) || tick_q) begin
      active_d = shadow_d;
    end
  end

  // Scan sequencer: state, digit index, phase counter and frame tick.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (!enable_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ON;
          idx_d   = '0;
          cnt_d   = DWELL_LD;
        end
        S_ON: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (BLANK > 0) begin
            state_d = S_BLANK;
            cnt_d   = BLANK_LD;
          end else begin
            idx_d = idx_next;
            cnt_d = DWELL_LD;
          end
        end
        S_BLANK: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = S_ON;
            idx_d   = idx_next;
            cnt_d   = DWELL_LD;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
      // With dead-time the tick marks the first blank after the last digit;
      // without it, the tick marks the last lit cycle of the last digit so
      // the copy lands exactly as idx wraps back to 0.
      if (BLANK > 0) begin
        tick_d = (state_q == S_ON) && (cnt_q == '0) && (idx_q == LAST_IDX);
      end else begin
        tick_d = (state_d == S_ON) && (cnt_d == '0) && (idx_d == LAST_IDX);
      end
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  // Leading-zero blanking: a zero stays dark while every higher digit is
  // zero or a blank code; digit 0 always shows.
  always_comb begin
    logic lead;
    lead     = 1'b1;
    lzb_mask = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (active_d[i] == 4'd0)) begin
        lzb_mask[i] = 1'b1;
      end
      lead = lead && ((active_d[i] == 4'd0) || (active_d[i] >= CODE_BLANK));
    end
  end
`else
  assign lzb_mask = '0;
`endif

  // Output pins are decoded from the next state so they are registered yet
  // line up with the state they belong to.
  always_comb begin
    an_d  = '0;
    seg_d = '0;
    if (state_d == S_ON) begin
      an_d[idx_d] = 1'b1;
      seg_d       = lzb_mask[idx_d] ? 7'd0 : decode(active_d[idx_d]);
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      shadow_q <= {DIGITS{CODE_BLANK}};
      active_q <= {DIGITS{CODE_BLANK}};
      seg_q    <= '0;
      an_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  // Digit select is never more than one-hot.
  a_an_onehot0: assert property (@(posedge clock_i) disable iff (reset_i)
    $onehot0(an_q));

  // While dark, nothing is shown on the segment bus.
  a_seg_dark: assert property (@(posedge clock_i) disable iff (reset_i)
    (an_q == '0) |-> (seg_q == '0));

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexes DIGITS digit codes onto one shared seven-segment bus plus a one-hot digit-select bus.
- Sits between the counter/control logic and the physical display pins.
- Sequences digit on-time and a dead-time between digits to suppress ghosting.
- Accepts digit updates through a valid/ready write port and applies them tear-free at frame boundaries.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8); AW = clog2(DIGITS), minimum 1
DWELL, 1000, clocks each digit is lit (>=1)
BLANK, 16, dead-time clocks between digits (0 = no dead-time)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = scan running, 0 = display dark
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_addr  in  AW  digit index (0 = rightmost)
wr_data  in  4  digit code
seg  out  7  segments abcdefg, a = MSB, active-high, registered
an  out  DIGITS  one-hot digit select, active-high, registered
frame_tick  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset: seg=0, an=0, frame_tick=0, wr_ready=1, state IDLE, idx=0, dwell/blank counters 0, all shadow and active digit codes = 13 (blank).
- Decode (combinational, sampled into seg):
  - 0-9 -> 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011
  - 10 -> P 1100111; 11 -> H 0110111; 12 -> dash 0000001; 13-15 -> 0000000
- Write port:
  - Handshake completes on a cycle with wr_valid & wr_ready; wr_data goes to shadow[wr_addr].
  - wr_addr >= DIGITS: handshake completes, data discarded.
  - Last write in a cycle wins.
- Active-copy rules:
  - Shadow is copied to active on each frame copy cycle (see BLANK/ON below).
  - In IDLE, active = shadow every cycle.
  - wr_ready = 0 only on a frame copy cycle; otherwise 1.
- States:
  - IDLE: seg=0, an=0. If enable=1, next cycle enter ON with idx=0.
  - ON: an=onehot(idx), seg=decode(active[idx]) for exactly DWELL cycles.
    - After DWELL cycles: enter BLANK if BLANK>0.
    - If BLANK=0: advance idx directly and stay in ON. Frame copy and frame_tick then occur on the wrap transition cycle.
  - BLANK: seg=0, an=0 for exactly BLANK cycles, then ON with idx+1 mod DIGITS.
    - If idx was DIGITS-1: frame_tick=1 on the first BLANK cycle, and that cycle is the frame copy cycle.
- Frame period: DIGITS*(DWELL+BLANK) clocks.
- an never has more than one bit set. an never changes between two digits within one cycle unless BLANK=0.
- enable falls in any state: next cycle IDLE, seg=0, an=0, idx=0, counters cleared. Shadow is preserved.
- reset mid-scan overrides enable and write: next cycle matches the reset state. A write presented in the reset cycle is lost.
- Write-to-display latency: a write is visible no later than the start of idx=0 ON after the next frame_tick. When started from IDLE it is visible in the first ON cycle.

Optional Feature:
- Macro: SEG7_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Scanning from the most significant digit (DIGITS-1) downward, each active code 0 is displayed as blank while all higher digits are 0 or blank.
  - Digit 0 is never blanked.
  - an timing is unchanged; only seg is forced to 0.
- Undefined: codes are displayed literally. Example: 0 shows 1111110 on every digit.

Test Plan (DIGITS=4, DWELL=4, BLANK=2 unless noted):
1. Reset, enable=1 -> 1 cycle after enable, an=0001, seg=0000000 (code 13) for 4 cycles, then an=0 for 2 cycles. Frame is 24 clocks; frame_tick pulses once every 24 cycles.
2. In IDLE, write addr0..3 = 1,2,10,11, then enable -> an=0001 seg=0110000, an=0010 seg=1101101, an=0100 seg=1100111, an=1000 seg=0110111.
3. While scanning, write addr2=9 mid-frame -> digit2 shows the old code until frame_tick. wr_ready=0 on the frame_tick cycle. From the next frame, an=0100 shows seg=1111011.
4. Drop enable during ON of digit 2 -> next cycle seg=0, an=0. Re-enable -> scan restarts at an=0001 with a full 4-cycle dwell.
5. BLANK=0, DWELL=1 -> an walks 0001, 0010, 0100, 1000, 0001 on consecutive cycles. frame_tick on the cycle idx wraps 3->0.
6. SEG7_SCAN_LZB_EN defined, codes {3:0, 2:0, 1:5, 0:0} -> digits 3 and 2 seg=0000000, digit1 seg=1011011, digit0 seg=1111110. Without the macro, digits 3 and 2 show 1111110.
